result_select_reg: RTL and testbench
====================================

# result_select_reg

Registered, parametrised result selector for the calculator datapath. It takes NUM_CH operation-result channels, each with a valid strobe. On a strobe it captures one winning result with fixed priority and holds it on a stable output for the display driver. It also gates the sign indicator per channel, flags simultaneous strobes, and blanks the display after an optional idle timeout.

## Interface
Parameters:
- WIDTH, 6, result magnitude width in bits
- NUM_CH, 3, number of result channels (≥2)
- SIGNED_MASK, 3'b100, bit i set = channel i may drive show_negative
- TIMEOUT, 0, cycles a result stays displayed after capture; 0 = hold forever

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch_valid  in  NUM_CH  one-cycle result strobe per channel
- ch_data  in  NUM_CH*WIDTH  channel i result at [i*WIDTH +: WIDTH]
- ch_negative  in  NUM_CH  sign of channel i result (1 = negative)
- clear  in  1  synchronous clear of displayed result and collision flag
- res  out  WIDTH  held result magnitude
- show_negative  out  1  minus-sign enable for display
- res_valid  out  1  high while a result is being displayed
- src_ch  out  max(1,$clog2(NUM_CH))  index of channel that supplied res
- update  out  1  one-cycle pulse on the cycle a new result appears
- collision  out  1  sticky: two or more ch_valid seen in the same cycle

## Operation
- States: IDLE (res_valid=0) and HOLD (res_valid=1).
- Capture: in any state, if any ch_valid bit is high, the lowest-index asserted channel k wins:
  - res ← ch_data[k]
  - show_negative ← ch_negative[k] & SIGNED_MASK[k]
  - src_ch ← k
  - go to HOLD, update ← 1, age counter ← 0
- A capture in HOLD overwrites the held result; update pulses again.
- Collision: if popcount(ch_valid) ≥ 2 in a cycle, collision sets and stays set until clear or reset. The capture still proceeds with the lowest index.
- Timeout (TIMEOUT > 0):
  - In HOLD with no capture, the age counter increments.
  - On the cycle age = TIMEOUT−1 with no capture, go to IDLE.
  - On entering IDLE: res ← 0, show_negative ← 0, src_ch ← 0.
  - Counter width is $clog2(TIMEOUT+1).
- TIMEOUT = 0: the counter is absent and HOLD persists until clear or reset.
- clear: go to IDLE, zero res, show_negative, src_ch and update, and drop collision.
- Priority within one cycle: clear > capture > timeout expiry.
  - clear together with ch_valid: result discarded, and collision is not set by that cycle.
  - Capture on the expiry cycle: stay in HOLD with the new result, counter ← 0.
- SIGNED_MASK bit 0 for a channel forces show_negative = 0 regardless of ch_negative.

## Timing
- Reset (asynchronous assert, synchronous release by design): state IDLE. res=0, show_negative=0, res_valid=0, src_ch=0, update=0, collision=0, counter=0.
- Reset mid-HOLD clears every output immediately, without waiting for a clock edge.
- All outputs are registered; no combinational input→output path.
- Latency: ch_valid sampled at edge N → res, res_valid, src_ch, show_negative and update valid after edge N (1 cycle).
- update is high exactly one cycle per capture. Back-to-back captures give update high on consecutive cycles.
- Display window: a single capture at edge N gives res_valid high for exactly TIMEOUT cycles. It falls after edge N+TIMEOUT.
- collision is visible after the same edge as the capture that caused it.
- clear takes effect after the edge at which it is sampled.

## Test plan
- Reset, then ch_valid=3'b010, ch_data ch1=6'd25 → next cycle: res=25, src_ch=1, res_valid=1, update=1 for one cycle, show_negative=0.
- SIGNED_MASK=3'b100: ch2 valid with data=6'd7, negative=1 → show_negative=1. Then ch0 valid with data=6'd7, negative=1 → show_negative=0, src_ch=0.
- ch_valid=3'b111 with data 10/20/30 → res=10, src_ch=0, collision=1. collision holds through later single strobes and drops only after clear.
- TIMEOUT=4, single capture at edge N → res_valid high for 4 cycles, then IDLE with res=0. A second capture at N+3 → window restarts, with res_valid still high at N+6.
- clear and ch_valid=3'b001 in the same cycle → IDLE, res=0, update=0. Assert rst_n=0 mid-HOLD → all outputs 0 without waiting for a clock edge.
- NUM_CH=5, WIDTH=8 instance, ch4 sole valid with data=8'hA5 → res=8'hA5, src_ch=3'd4.

Source files
------------

// File: rtl/result_select_reg.sv
// result_select_reg: registered fixed-priority result selector for the
// calculator display path. Captures the lowest-index strobed channel, holds it
// for the display driver, gates the sign per channel, flags simultaneous
// strobes and optionally blanks the display after an idle timeout.
module result_select_reg #(
  parameter int                WIDTH       = 6,
  parameter int                NUM_CH      = 3,
  parameter logic [NUM_CH-1:0] SIGNED_MASK = 3'b100,
  parameter int                TIMEOUT     = 0,
  localparam int               SRC_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_negative,
  input  logic                    clear,
  output logic [WIDTH-1:0]        res,
  output logic                    show_negative,
  output logic                    res_valid,
  output logic [SRC_W-1:0]        src_ch,
  output logic                    update,
  output logic                    collision
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [NUM_CH-1:0] CH_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  // Registered state and outputs
  state_t              r_state;
  logic [WIDTH-1:0]    r_res;
  logic                r_neg;
  logic [SRC_W-1:0]    r_src;
  logic                r_upd;
  logic                r_coll;

  // Next-state values
  state_t              w_state_next;
  logic [WIDTH-1:0]    w_res_next;
  logic                w_neg_next;
  logic [SRC_W-1:0]    w_src_next;
  logic                w_upd_next;
  logic                w_coll_next;

  // Capture decode
  logic [NUM_CH-1:0]   w_neg_masked;
  logic                w_any;
  logic                w_multi;
  logic [SRC_W-1:0]    w_win_idx;
  logic [WIDTH-1:0]    w_win_data;
  logic                w_win_neg;
  logic                w_expire;

  // Sign is only allowed through for channels that can produce negatives
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_sign_gate
      assign w_neg_masked[gi] = ch_negative[gi] & SIGNED_MASK[gi];
    end
  endgenerate

  assign w_any = |ch_valid;
  // Clearing the lowest set bit leaves something only if two or more were set
  assign w_multi = |(ch_valid & (ch_valid - CH_ONE));

  // Fixed-priority pick: scan downward so the lowest asserted index wins
  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    w_win_neg  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        w_win_idx  = SRC_W'(i);
        w_win_data = ch_data[i*WIDTH +: WIDTH];
        w_win_neg  = w_neg_masked[i];
      end
    end
  end

  // Optional display-age counter; absent entirely when results hold forever
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      logic [CNT_W-1:0] r_age;

      assign w_expire = (r_state == ST_HOLD) && (r_age == CNT_W'(TIMEOUT - 1));

      // Age restarts on every capture and stays at zero outside HOLD
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_age <= '0;
        end else if (clear || w_any || (r_state != ST_HOLD) || w_expire) begin
          r_age <= '0;
        end else begin
          r_age <= r_age + CNT_W'(1);
        end
      end
    end else begin : g_no_timeout
      assign w_expire = 1'b0;
    end
  endgenerate

  // Next-state: clear beats capture, capture beats timeout expiry
  always_comb begin
    w_state_next = r_state;
    w_res_next   = r_res;
    w_neg_next   = r_neg;
    w_src_next   = r_src;
    w_upd_next   = 1'b0;
    w_coll_next  = r_coll;
    if (clear) begin
      w_state_next = ST_IDLE;
      w_res_next   = '0;
      w_neg_next   = 1'b0;
      w_src_next   = '0;
      w_coll_next  = 1'b0;
    end else begin
      if (w_multi) begin
        w_coll_next = 1'b1;
      end
      if (w_any) begin
        w_state_next = ST_HOLD;
        w_res_next   = w_win_data;
        w_neg_next   = w_win_neg;
        w_src_next   = w_win_idx;
        w_upd_next   = 1'b1;
      end else if (w_expire) begin
        w_state_next = ST_IDLE;
        w_res_next   = '0;
        w_neg_next   = 1'b0;
        w_src_next   = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_res   <= '0;
      r_neg   <= 1'b0;
      r_src   <= '0;
      r_upd   <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_res   <= w_res_next;
      r_neg   <= w_neg_next;
      r_src   <= w_src_next;
      r_upd   <= w_upd_next;
      r_coll  <= w_coll_next;
    end
  end

  assign res           = r_res;
  assign show_negative = r_neg;
  assign res_valid     = (r_state == ST_HOLD);
  assign src_ch        = r_src;
  assign update        = r_upd;
  assign collision     = r_coll;

endmodule

// File: tb/tb_result_select_reg.sv
// Testbench for result_select_reg: three instances (timeout, hold-forever,
// wide 5-channel) driven by directed and random stimulus and compared
// each cycle against a display-window reference model.
module tb_result_select_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  v3, n3;
  logic [17:0] d3;
  logic [4:0]  v5, n5;
  logic [39:0] d5;
  logic        clr;

  logic [5:0] a_res;  logic a_neg, a_valid, a_upd, a_coll;  logic [1:0] a_src;
  logic [5:0] b_res;  logic b_neg, b_valid, b_upd, b_coll;  logic [1:0] b_src;
  logic [7:0] c_res;  logic c_neg, c_valid, c_upd, c_coll;  logic [2:0] c_src;

  result_select_reg #(.WIDTH(6), .NUM_CH(3), .SIGNED_MASK(3'b100), .TIMEOUT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ch_valid(v3), .ch_data(d3), .ch_negative(n3), .clear(clr),
    .res(a_res), .show_negative(a_neg), .res_valid(a_valid), .src_ch(a_src),
    .update(a_upd), .collision(a_coll));

  result_select_reg #(.WIDTH(6), .NUM_CH(3), .SIGNED_MASK(3'b100), .TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ch_valid(v3), .ch_data(d3), .ch_negative(n3), .clear(clr),
    .res(b_res), .show_negative(b_neg), .res_valid(b_valid), .src_ch(b_src),
    .update(b_upd), .collision(b_coll));

  result_select_reg #(.WIDTH(8), .NUM_CH(5), .SIGNED_MASK(5'b10110), .TIMEOUT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .ch_valid(v5), .ch_data(d5), .ch_negative(n5), .clear(clr),
    .res(c_res), .show_negative(c_neg), .res_valid(c_valid), .src_ch(c_src),
    .update(c_upd), .collision(c_coll));

  // Reference model: remaining display cycles instead of an age counter
  typedef struct packed {
    bit vld;
    int res;
    bit neg;
    int src;
    bit upd;
    bit coll;
    int remain;
  } mstate_t;

  mstate_t ma, mb, mc;
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic mstate_t mstep(input mstate_t s, input int t, input int n, input int w,
                                    input logic [4:0] v, input logic [39:0] d,
                                    input logic [4:0] ng, input logic [4:0] mask, input bit c);
    mstate_t o;
    int cnt;
    int k;
    o = s;
    o.upd = 1'b0;
    if (c) begin
      o = '0;
      return o;
    end
    k = -1;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        cnt++;
        if (k < 0) k = i;
      end
    end
    if (cnt >= 2) o.coll = 1'b1;
    if (k >= 0) begin
      o.vld    = 1'b1;
      o.res    = int'((d >> (k * w)) & ((40'd1 << w) - 40'd1));
      o.neg    = ng[k] & mask[k];
      o.src    = k;
      o.upd    = 1'b1;
      o.remain = t;
    end else if (s.vld && t > 0) begin
      o.remain = s.remain - 1;
      if (o.remain == 0) begin
        o.vld = 1'b0;
        o.res = 0;
        o.neg = 1'b0;
        o.src = 0;
      end
    end
    return o;
  endfunction

  task automatic compare_all();
    check("A.res", a_res, ma.res);   check("A.neg", a_neg, ma.neg);
    check("A.valid", a_valid, ma.vld); check("A.src", a_src, ma.src);
    check("A.upd", a_upd, ma.upd);   check("A.coll", a_coll, ma.coll);
    check("B.res", b_res, mb.res);   check("B.neg", b_neg, mb.neg);
    check("B.valid", b_valid, mb.vld); check("B.src", b_src, mb.src);
    check("B.upd", b_upd, mb.upd);   check("B.coll", b_coll, mb.coll);
    check("C.res", c_res, mc.res);   check("C.neg", c_neg, mc.neg);
    check("C.valid", c_valid, mc.vld); check("C.src", c_src, mc.src);
    check("C.upd", c_upd, mc.upd);   check("C.coll", c_coll, mc.coll);
  endtask

  // One clocked transaction: drive, clock, advance model, compare
  task automatic step(input logic [2:0] iv3, input logic [17:0] id3, input logic [2:0] in3,
                      input logic [4:0] iv5, input logic [39:0] id5, input logic [4:0] in5,
                      input logic iclr);
    v3 = iv3; d3 = id3; n3 = in3;
    v5 = iv5; d5 = id5; n5 = in5;
    clr = iclr;
    @(posedge clk);
    ma = mstep(ma, 4, 3, 6, {2'b00, iv3}, {22'd0, id3}, {2'b00, in3}, 5'b00100, iclr);
    mb = mstep(mb, 0, 3, 6, {2'b00, iv3}, {22'd0, id3}, {2'b00, in3}, 5'b00100, iclr);
    mc = mstep(mc, 3, 5, 8, iv5, id5, in5, 5'b10110, iclr);
    #1;
    cyc++;
    $display("[TB] cyc %0d v3=%b v5=%b clr=%b | A res=%0d v=%b u=%b c=%b | B res=%0d v=%b | C res=%0d v=%b src=%0d",
             cyc, iv3, iv5, iclr, a_res, a_valid, a_upd, a_coll, b_res, b_valid, c_res, c_valid, c_src);
    compare_all();
  endtask

  task automatic idle3();
    step(3'b000, 18'd0, 3'b000, 5'b00000, 40'd0, 5'b00000, 1'b0);
  endtask

  logic [2:0]  rv3, rn3;
  logic [17:0] rd3;
  logic [4:0]  rv5, rn5;
  logic [39:0] rd5;
  logic        rclr;

  initial begin
    v3 = '0; n3 = '0; d3 = '0; v5 = '0; n5 = '0; d5 = '0; clr = 1'b0;
    ma = '0; mb = '0; mc = '0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Single capture on channel 1
    step(3'b010, {6'd0, 6'd25, 6'd0}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    check("dir.res25", a_res, 25); check("dir.src1", a_src, 1);
    check("dir.valid", a_valid, 1); check("dir.upd1", a_upd, 1); check("dir.neg0", a_neg, 0);
    idle3();
    check("dir.upd_drop", a_upd, 0); check("dir.still_valid", a_valid, 1);

    // Sign gating by channel
    step(3'b100, {6'd7, 12'd0}, 3'b100, 5'b0, 40'd0, 5'b0, 1'b0);
    check("dir.neg_ch2", a_neg, 1);
    step(3'b001, {12'd0, 6'd7}, 3'b001, 5'b0, 40'd0, 5'b0, 1'b0);
    check("dir.neg_ch0", a_neg, 0); check("dir.src0", a_src, 0);

    // Collision: lowest index wins, flag sticky until clear
    step(3'b111, {6'd30, 6'd20, 6'd10}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    check("dir.coll_res", a_res, 10); check("dir.coll_src", a_src, 0); check("dir.coll_set", a_coll, 1);
    step(3'b010, {6'd0, 6'd3, 6'd0}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    check("dir.coll_hold", a_coll, 1);
    step(3'b000, 18'd0, 3'b000, 5'b0, 40'd0, 5'b0, 1'b1);
    check("dir.coll_clear", a_coll, 0); check("dir.clear_valid", a_valid, 0);

    // Timeout window of four cycles
    step(3'b001, {12'd0, 6'd9}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    idle3(); idle3(); idle3();
    check("dir.window_last", a_valid, 1);
    idle3();
    check("dir.window_end", a_valid, 0); check("dir.window_res0", a_res, 0);
    check("dir.hold_forever", b_valid, 1);

    // Window restart by a second capture three cycles later
    step(3'b001, {12'd0, 6'd11}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    idle3(); idle3();
    step(3'b010, {6'd0, 6'd12, 6'd0}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    idle3(); idle3(); idle3();
    check("dir.restart_valid", a_valid, 1);
    idle3();
    check("dir.restart_end", a_valid, 0);

    // Clear together with a strobe discards the result
    step(3'b001, {12'd0, 6'd5}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b0);
    step(3'b001, {12'd0, 6'd6}, 3'b000, 5'b0, 40'd0, 5'b0, 1'b1);
    check("dir.clrcap_valid", a_valid, 0); check("dir.clrcap_res", a_res, 0); check("dir.clrcap_upd", a_upd, 0);

    // Wide instance, top channel
    step(3'b010, {6'd0, 6'd33, 6'd0}, 3'b000, 5'b10000, {8'hA5, 32'd0}, 5'b10000, 1'b0);
    check("dir.wide_res", c_res, 8'hA5); check("dir.wide_src", c_src, 4); check("dir.wide_neg", c_neg, 1);

    // Asynchronous reset mid-HOLD, checked between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    ma = '0; mb = '0; mc = '0;
    check("dir.rst_a_valid", a_valid, 0); check("dir.rst_a_res", a_res, 0);
    check("dir.rst_c_valid", c_valid, 0);
    compare_all();
    #2;
    rst_n = 1'b1;

    // Random traffic with quiet stretches so timeouts expire
    for (int r = 0; r < 600; r++) begin
      rv3 = '0; rv5 = '0;
      if ((r % 40) >= 12) begin
        for (int b = 0; b < 3; b++) rv3[b] = ($urandom_range(0, 3) == 0);
        for (int b = 0; b < 5; b++) rv5[b] = ($urandom_range(0, 4) == 0);
      end
      rd3  = 18'($urandom);
      rn3  = 3'($urandom);
      rd5  = {8'($urandom), 32'($urandom)};
      rn5  = 5'($urandom);
      rclr = ($urandom_range(0, 24) == 0);
      step(rv3, rd3, rn3, rv5, rd5, rn5, rclr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
